// File: rtl/uart_tx.sv
// uart_tx: serial UART transmitter, start + LSB-first data + optional parity + stop
module uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int DW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state;
    logic [CW-1:0]         bit_cnt;
    logic [DW-1:0]         data_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bit;
    logic                  par_en_q;
    logic                  bit_end;
    logic                  data_last;

    assign bit_end   = bit_cnt == CW'(CLKS_PER_BIT - 1);
    assign data_last = data_cnt == DW'(DATA_WIDTH - 1);

    // frame sequencer; every output is registered and each slot lasts CLKS_PER_BIT cycles
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            tx_out   <= 1'b1;
            busy     <= 1'b0;
            bit_cnt  <= '0;
            data_cnt <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            par_en_q <= 1'b0;
        end else begin
            if (state != IDLE) bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
            case (state)
                IDLE: if (data_valid) begin
                    state    <= START;
                    tx_out   <= 1'b0;
                    busy     <= 1'b1;
                    shreg    <= p_data;
                    par_en_q <= par_en;
                    par_bit  <= par_typ ? ~^p_data : ^p_data;
                    bit_cnt  <= '0;
                end
                START: if (bit_end) begin
                    state    <= DATA;
                    tx_out   <= shreg[0];
                    shreg    <= shreg >> 1;
                    data_cnt <= '0;
                end
                DATA: if (bit_end) begin
                    if (data_last) begin
                        state  <= par_en_q ? PARITY : STOP;
                        tx_out <= par_en_q ? par_bit : 1'b1;
                    end else begin
                        data_cnt <= data_cnt + 1'b1;
                        tx_out   <= shreg[0];
                        shreg    <= shreg >> 1;
                    end
                end
                PARITY: if (bit_end) begin
                    state  <= STOP;
                    tx_out <= 1'b1;
                end
                STOP: if (bit_end) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx at one and four clocks per bit
module tb_uart_tx;
    localparam int W = 8;

    typedef struct {
        int          inst;
        logic [63:0] bits;
        int          len;
        logic [W-1:0] word;
        logic        pe;
        logic        pt;
        logic [63:0] lit;
        int          lit_len;
    } frame_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] pd[2];
    logic         dv[2];
    logic         pe[2];
    logic         pt[2];
    logic         tx[2];
    logic         bz[2];

    frame_t       sbq[$];
    int           rem[2]     = '{0, 0};
    logic         mbusy[2]   = '{1'b0, 1'b0};
    int           aborts[2]  = '{0, 0};
    logic [63:0]  lit_next   = '0;
    int           lit_len_next = 0;
    logic         done = 1'b0;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic         prev[2]    = '{1'b0, 1'b0};
    logic [63:0]  cap[2];
    int           cap_len[2];
    logic         have[2]    = '{1'b0, 1'b0};
    int           seen_ab[2] = '{0, 0};
    frame_t       cur[2];

    always #5 clk = ~clk;

    uart_tx #(.DATA_WIDTH(W), .CLKS_PER_BIT(1)) u0 (
        .clk(clk), .rst(rst), .p_data(pd[0]), .data_valid(dv[0]),
        .par_en(pe[0]), .par_typ(pt[0]), .tx_out(tx[0]), .busy(bz[0])
    );
    uart_tx #(.DATA_WIDTH(W), .CLKS_PER_BIT(4)) u1 (
        .clk(clk), .rst(rst), .p_data(pd[1]), .data_valid(dv[1]),
        .par_en(pe[1]), .par_typ(pt[1]), .tx_out(tx[1]), .busy(bz[1])
    );

    function automatic int cpb(int i);
        return i == 0 ? 1 : 4;
    endfunction

    // expected line, one entry per clock: slots are start, data LSB first, parity, stop
    function automatic frame_t mk(int i, logic [W-1:0] w, logic e, logic t);
        frame_t f;
        logic   sb[$];
        int     n = 0;
        sb.push_back(1'b0);
        for (int k = 0; k < W; k++) sb.push_back(w[k]);
        if (e) sb.push_back((($countones(w) % 2) == 1) ^ t);
        sb.push_back(1'b1);
        f.bits = '0;
        foreach (sb[s])
            for (int r = 0; r < cpb(i); r++) begin
                f.bits[n] = sb[s];
                n++;
            end
        f.inst = i; f.len = n; f.word = w; f.pe = e; f.pt = t;
        f.lit = lit_next; f.lit_len = lit_len_next;
        return f;
    endfunction

    // reference: a request is taken when the model has no frame in flight and rst is high
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                if (rem[i] > 0) aborts[i]++;
                rem[i] = 0;
            end else if (rem[i] > 0) begin
                rem[i]--;
            end else if (dv[i]) begin
                sbq.push_back(mk(i, pd[i], pe[i], pt[i]));
                rem[i] = cpb(i) * (2 + W + (pe[i] ? 1 : 0));
            end
            mbusy[i] = rem[i] > 0;
        end
    end

    // monitor: per-cycle busy/idle line check, frame capture and scoreboard compare
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (bz[i] !== mbusy[i] || (!mbusy[i] && tx[i] !== 1'b1)) begin
                n_bad++;
                $display("FAIL line inst%0d t=%0t: busy=%b tx=%b want busy=%b", i, $time, bz[i], tx[i], mbusy[i]);
            end
            if (bz[i] === 1'b1 && !prev[i]) begin
                cap[i] = '0;
                cap_len[i] = 0;
                have[i] = 1'b0;
                n_cmp++;
                if (sbq.size() == 0 || sbq[0].inst != i) begin
                    n_bad++;
                    $display("FAIL spurious inst%0d t=%0t: frame started, none expected", i, $time);
                end else begin
                    cur[i] = sbq.pop_front();
                    have[i] = 1'b1;
                end
            end
            if (bz[i] === 1'b1 && cap_len[i] < 64) begin
                cap[i][cap_len[i]] = tx[i];
                cap_len[i]++;
            end
            if (bz[i] !== 1'b1 && prev[i]) begin
                if (aborts[i] != seen_ab[i]) begin
                    seen_ab[i] = aborts[i];
                end else if (have[i]) begin
                    int          c;
                    logic [W-1:0] rw;
                    logic        perr, serr;
                    c = cpb(i);
                    n_cmp++;
                    if (cap_len[i] != cur[i].len || cap[i] !== cur[i].bits) begin
                        n_bad++;
                        $display("FAIL frame inst%0d word=%h: got len=%0d bits=%h want len=%0d bits=%h",
                                 i, cur[i].word, cap_len[i], cap[i], cur[i].len, cur[i].bits);
                    end
                    for (int k = 0; k < W; k++) rw[k] = cap[i][(1 + k) * c + c / 2];
                    perr = cur[i].pe && (cap[i][(1 + W) * c + c / 2] !== (((^rw) ^ cur[i].pt) === 1'b1));
                    serr = cap_len[i] < 1 || cap[i][cap_len[i] - 1] !== 1'b1;
                    n_cmp++;
                    if (rw !== cur[i].word || perr || serr) begin
                        n_bad++;
                        $display("FAIL rx inst%0d: got word=%h par_error=%b stop_error=%b want word=%h par_error=0 stop_error=0",
                                 i, rw, perr, serr, cur[i].word);
                    end
                    if (cur[i].lit_len > 0) begin
                        n_cmp++;
                        if (cap_len[i] != cur[i].lit_len || cap[i] !== cur[i].lit) begin
                            n_bad++;
                            $display("FAIL directed inst%0d word=%h: got len=%0d bits=%h want len=%0d bits=%h",
                                     i, cur[i].word, cap_len[i], cap[i], cur[i].lit_len, cur[i].lit);
                        end
                    end
                end
                have[i] = 1'b0;
            end
            prev[i] = bz[i] === 1'b1;
        end
        if (done) begin
            n_cmp++;
            if (sbq.size() != 0 || have[0] || have[1]) begin
                n_bad++;
                $display("FAIL drain: %0d frames never seen, want 0", sbq.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    task automatic send(input int i, input logic [W-1:0] w, input logic e, input logic t,
                        input logic [63:0] lit, input int lit_len);
        @(posedge clk); #1;
        pd[i] = w; pe[i] = e; pt[i] = t; dv[i] = 1'b1;
        lit_next = lit; lit_len_next = lit_len;
        @(posedge clk); #1;
        dv[i] = 1'b0; lit_len_next = 0;
    endtask

    task automatic idle(input int i);
        for (int k = 0; k < 200 && rem[i] != 0; k++) @(posedge clk);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            pd[i] = '0; dv[i] = 1'b0; pe[i] = 1'b0; pt[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        send(0, 8'hA5, 1'b0, 1'b0, 64'h34A, 10); idle(0);
        send(0, 8'h3C, 1'b1, 1'b0, 64'h478, 11); idle(0);
        send(0, 8'h3C, 1'b1, 1'b1, 64'h678, 11); idle(0);
        send(0, 8'h01, 1'b0, 1'b0, 64'h202, 10);
        repeat (2) @(posedge clk);
        #1 pd[0] = 8'hFF; pe[0] = ~pe[0]; dv[0] = 1'b1;
        @(posedge clk); #1 dv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 pd[0] = 8'hFF; pe[0] = ~pe[0]; dv[0] = 1'b1;
        @(posedge clk); #1 dv[0] = 1'b0;
        idle(0);
        send(0, 8'h00, 1'b0, 1'b0, 64'h0, 0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        idle(0);
        send(0, 8'h00, 1'b0, 1'b0, 64'h200, 10); idle(0);
        pd[0] = 8'h55; pe[0] = 1'b1; pt[0] = 1'b1; dv[0] = 1'b1;
        repeat (36) @(posedge clk);
        #1 dv[0] = 1'b0;
        idle(0);
        send(1, 8'h81, 1'b0, 1'b0, 64'h000000FF_000000F0, 40); idle(1);
        for (int n = 0; n < 8; n++) begin
            send(1, W'($urandom), 1'($urandom), 1'($urandom), 64'h0, 0);
            idle(1);
        end
        for (int n = 0; n < 256; n++) begin
            send(0, W'($urandom), 1'($urandom), 1'($urandom), 64'h0, 0);
            idle(0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        @(posedge clk); #1 done = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, the transmit-side counterpart of the team's UART receiver. It accepts one parallel data word per handshake and emits a frame on a single line: start bit (0), DATA_WIDTH data bits LSB-first, an optional parity bit, then a stop bit (1). Frame configuration matches the receiver's `par_en`/`par_typ` controls. With CLKS_PER_BIT = 1 the block drives one bit per `clk`, so it loops back directly into the receiver.

## Interface
- DATA_WIDTH, 8, data bits per frame (≥1)
- CLKS_PER_BIT, 1, clk cycles each serial bit is held (≥1)
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-low
- p_data  input  DATA_WIDTH  word to transmit, sampled on accept
- data_valid  input  1  request to transmit p_data
- par_en  input  1  1 = parity bit inserted, sampled on accept
- par_typ  input  1  0 = even parity, 1 = odd parity, sampled on accept
- tx_out  output  1  serial line, idles high
- busy  output  1  frame in progress; requests ignored while 1

## Operation
- FSM states:
  - IDLE → START → DATA → (PARITY if par_en latched) → STOP → IDLE.
- Accept:
  - An accept occurs on a rising edge with rst = 1, state = IDLE and data_valid = 1.
  - On accept, latch p_data into a shift register, latch par_en and par_typ, and compute the parity bit.
  - Even parity (par_typ = 0): parity bit = ^p_data.
  - Odd parity (par_typ = 1): parity bit = ~^p_data.
- Bit counter: counts CLKS_PER_BIT cycles per bit.
- Data counter: counts DATA_WIDTH bits in DATA. Data shifts right, and tx_out takes bit 0.
- Output register: tx_out and busy are registered. No combinational path exists from any input to any output.
- tx_out value per state:
  - IDLE: 1
  - START: 0
  - DATA: current data bit
  - PARITY: latched parity bit
  - STOP: 1
- Busy requests: data_valid while busy = 1 is ignored. There is no queueing, and latched data and config are unaffected.
- Input changes after accept: changes to p_data, par_en or par_typ have no effect on the frame in flight.
- Reset:
  - rst = 0 at any edge forces state IDLE, tx_out = 1, busy = 0, and clears all counters.
  - This includes reset mid-frame, which aborts the frame with no partial stop bit.
  - Reset takes priority over data_valid on the same edge.

## Timing
- Reset values: tx_out = 1, busy = 0, state IDLE, counters 0, shift register 0.
- Let accept happen at edge N and let C = CLKS_PER_BIT.
- Start bit:
  - From edge N+1, busy = 1 and tx_out = 0.
  - The start bit is held for cycles N+1 … N+C.
- Data bit k (k = 0 … DATA_WIDTH-1) occupies edges N+1+(1+k)·C through N+(2+k)·C.
- Parity, if enabled, occupies the bit slot directly after the last data bit.
- Frame length:
  - F = (2 + DATA_WIDTH + par_en)·C cycles.
  - With defaults: 10 cycles without parity, 11 with parity.
- End of frame:
  - The stop bit is the last slot of the frame.
  - At edge N+F+1 the state returns to IDLE, busy = 0 and tx_out = 1.
- Earliest next accept is edge N+F+1. The next start bit then begins at N+F+2.
  - So at least one idle cycle with tx_out = 1 separates back-to-back frames.
- data_valid held high continuously gives one frame every F+1 cycles.

## Test plan
- Reset then C = 1, p_data = 0xA5, par_en = 0, one-cycle data_valid:
  - Expect tx_out sequence 0,1,0,1,0,0,1,0,1,1.
  - Expect busy high for exactly 10 cycles, then tx_out = 1 and busy = 0.
- p_data = 0x3C, par_en = 1, par_typ = 0:
  - Expect 0, then 0,0,1,1,1,1,0,0, then parity 0, then stop 1.
  - busy is high for 11 cycles.
  - Repeat with par_typ = 1: expect parity bit 1.
- p_data = 0x01 accepted, then data_valid pulsed with p_data = 0xFF and par_en toggled at frame cycles 3 and 7:
  - Frame is unchanged: 0,1,0,0,0,0,0,0,0,1.
  - No second frame starts.
- Reset asserted at frame cycle 5 of a 0x00 frame:
  - On the next edge tx_out = 1 and busy = 0.
  - A new request after rst = 1 produces a complete, correct frame.
- data_valid held high, p_data = 0x55, par_en = 1, par_typ = 1:
  - Expect frames every 12 cycles, each with parity 1.
  - Exactly one idle high cycle between consecutive stop bits and start bits.
- CLKS_PER_BIT = 4, p_data = 0x81, no parity:
  - Each bit is held exactly 4 cycles, for 40 busy cycles total.
  - Additionally, with C = 1, loop tx_out into the receiver (start held for the frame) and check received word = sent word, par_error = 0, stop_error = 0, for 256 random words in all parity modes.
